// File: rtl/pong_pkg.sv
// Shared definitions for the pong playfield blocks: default playfield height,
// paddle width lookup and the button repeat state machine encoding.
package pong_pkg;

  // Playfield height shared by the paddle, ball and collision blocks.
  localparam int ROWS_DEF = 16;

  // Hold-to-repeat state machine for manual paddle control.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  // Resolved button direction; both or neither held means no direction.
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  // Map the 2-bit width select onto a paddle height in rows.
  function automatic int width_to_rows(input logic [1:0] width,
                                       input int w0, input int w1,
                                       input int w2, input int w3);
    int rows;
    case (width)
      2'd0:    rows = w0;
      2'd1:    rows = w1;
      2'd2:    rows = w2;
      2'd3:    rows = w3;
      default: rows = w0;
    endcase
    return rows;
  endfunction

endpackage

// File: rtl/paddle_ctrl_btn_sync_edge.sv
// Button conditioning: two-flop synchroniser for an asynchronous push button,
// followed by a history flop so a rising edge can be reported as a one-cycle press.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  logic meta_r;
  logic sync_r;
  logic hist_r;

  // Synchronise the raw button and keep one cycle of history for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      hist_r <= 1'b0;
    end else begin
      meta_r <= btn;
      sync_r <= meta_r;
      hist_r <= sync_r;
    end
  end

  assign level = sync_r;
  assign press = sync_r & ~hist_r;

endmodule

// File: rtl/paddle_ctrl.sv
// One player's paddle: position register with selectable height, button
// press/hold-to-repeat control, CPU tracking mode, width-change clamping and
// the ROWS-bit occupancy mask used by display and collision logic.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter  int ROWS         = ROWS_DEF,
  parameter  int W0           = 8,
  parameter  int W1           = 6,
  parameter  int W2           = 4,
  parameter  int W3           = 2,
  parameter  int REPEAT_DELAY = 12,
  parameter  int REPEAT_RATE  = 3,
  localparam int PW           = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic [1:0]      width,
  input  logic            up,
  input  logic            down,
  input  logic            auto_en,
  input  logic [PW-1:0]   target,
  output logic [ROWS-1:0] paddle_o,
  output logic [PW-1:0]   pos_o,
  output logic            at_top,
  output logic            at_bottom
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Row arithmetic is done one bit wider than a position so pos+W never wraps.
  localparam logic [PW:0]   ROWS_X     = (PW + 1)'(ROWS);
  localparam logic [PW-1:0] POS_ONE    = PW'(1'b1);
  localparam logic [PW-1:0] POS_ZERO   = PW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(1'b0);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

  logic            up_lvl_s;
  logic            up_press_s;
  logic            dn_lvl_s;
  logic            dn_press_s;

  logic [PW:0]     w_s;
  logic [PW:0]     end_s;
  logic [PW:0]     centre_s;
  logic [PW-1:0]   rst_pos_s;

  dir_e            dir_s;
  logic            dir_press_s;
  logic            step_s;
  logic            mv_up_s;
  logic            mv_dn_s;

  rep_state_e      state_r;
  rep_state_e      state_n;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_n;
  logic [PW-1:0]   pos_r;
  logic [PW-1:0]   pos_n;

  btn_sync_edge u_up_sync (
    .clk   (clk),
    .reset (reset),
    .btn   (up),
    .level (up_lvl_s),
    .press (up_press_s)
  );

  btn_sync_edge u_dn_sync (
    .clk   (clk),
    .reset (reset),
    .btn   (down),
    .level (dn_lvl_s),
    .press (dn_press_s)
  );

  // Paddle geometry derived from the current width select and position.
  always_comb begin
    w_s       = (PW + 1)'(width_to_rows(width, W0, W1, W2, W3));
    end_s     = {1'b0, pos_r} + w_s;
    centre_s  = {1'b0, pos_r} + (w_s >> 1);
    rst_pos_s = PW'((ROWS_X - w_s) >> 1);
  end

  // Resolve the held buttons into a single direction and its press strobe.
  always_comb begin
    dir_s       = DIR_NONE;
    dir_press_s = 1'b0;
    if (up_lvl_s && !dn_lvl_s) begin
      dir_s       = DIR_UP;
      dir_press_s = up_press_s;
    end else if (dn_lvl_s && !up_lvl_s) begin
      dir_s       = DIR_DOWN;
      dir_press_s = dn_press_s;
    end else begin
      dir_s       = DIR_NONE;
      dir_press_s = 1'b0;
    end
  end

  // Repeat state and tick counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Hold-to-repeat next state: a fresh press in the held direction always
  // moves once and restarts the delay, which also covers direction changes.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    step_s  = 1'b0;
    if (auto_en || dir_s == DIR_NONE) begin
      state_n = ST_IDLE;
      cnt_n   = CNT_ZERO;
    end else if (dir_press_s) begin
      step_s  = 1'b1;
      state_n = ST_DELAY;
      cnt_n   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_n = ST_IDLE;
          cnt_n   = CNT_ZERO;
        end
        ST_DELAY: begin
          if (tick && cnt_r == DELAY_LAST) begin
            step_s  = 1'b1;
            state_n = ST_REPEAT;
            cnt_n   = CNT_ZERO;
          end else if (tick) begin
            cnt_n = cnt_r + CNT_ONE;
          end else begin
            cnt_n = cnt_r;
          end
        end
        ST_REPEAT: begin
          if (tick && cnt_r == RATE_LAST) begin
            step_s = 1'b1;
            cnt_n  = CNT_ZERO;
          end else if (tick) begin
            cnt_n = cnt_r + CNT_ONE;
          end else begin
            cnt_n = cnt_r;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = CNT_ZERO;
        end
      endcase
    end
  end

  // Move requests from either the manual FSM or the CPU tracker.
  always_comb begin
    mv_up_s = 1'b0;
    mv_dn_s = 1'b0;
    if (auto_en) begin
      mv_up_s = tick && ({1'b0, target} < centre_s);
      mv_dn_s = tick && ({1'b0, target} > centre_s);
    end else begin
      mv_up_s = step_s && (dir_s == DIR_UP);
      mv_dn_s = step_s && (dir_s == DIR_DOWN);
    end
  end

  // Next position: clamping after a width change beats any move; moves
  // against an edge are swallowed.
  always_comb begin
    pos_n = pos_r;
    if (end_s > ROWS_X) begin
      pos_n = PW'(ROWS_X - w_s);
    end else if (mv_up_s && pos_r != POS_ZERO) begin
      pos_n = pos_r - POS_ONE;
    end else if (mv_dn_s && end_s < ROWS_X) begin
      pos_n = pos_r + POS_ONE;
    end else begin
      pos_n = pos_r;
    end
  end

  // Position register; reset centres the paddle for the current width.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_r <= rst_pos_s;
    end else begin
      pos_r <= pos_n;
    end
  end

  // Occupancy mask, built per row so an unclamped paddle is cut at the last row.
  always_comb begin
    paddle_o = {ROWS{1'b0}};
    for (int i = 0; i < ROWS; i++) begin
      paddle_o[i] = ({1'b0, pos_r} <= (PW + 1)'(i)) && ((PW + 1)'(i) < end_s);
    end
  end

  assign pos_o     = pos_r;
  assign at_top    = (pos_r == POS_ZERO);
  assign at_bottom = (end_s == ROWS_X);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with default parameters.
module tb_paddle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [1:0]  width;
  logic        up;
  logic        down;
  logic        auto_en;
  logic [3:0]  target;
  logic [15:0] paddle_o;
  logic [3:0]  pos_o;
  logic        at_top;
  logic        at_bottom;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  paddle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .width     (width),
    .up        (up),
    .down      (down),
    .auto_en   (auto_en),
    .target    (target),
    .paddle_o  (paddle_o),
    .pos_o     (pos_o),
    .at_top    (at_top),
    .at_bottom (at_bottom)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(3);
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b0; width = 2'd0; up = 1'b0; down = 1'b0;
    auto_en = 1'b0; target = 4'd0;
    step(2);
    reset = 1'b0;
    n_cmp++; if (pos_o !== 4'd4) begin n_err++; $display("FAIL reset_pos got %0d exp 4", pos_o); end
    n_cmp++; if (paddle_o !== 16'h0FF0) begin n_err++; $display("FAIL reset_mask got %h exp 0ff0", paddle_o); end
    n_cmp++; if (at_top !== 1'b0) begin n_err++; $display("FAIL reset_top got %b exp 0", at_top); end
    n_cmp++; if (at_bottom !== 1'b0) begin n_err++; $display("FAIL reset_bottom got %b exp 0", at_bottom); end
  endtask

  task automatic test_single_press();
    up = 1'b1;
    step(1);
    n_cmp++; if (pos_o !== 4'd4) begin n_err++; $display("FAIL press_lat1 got %0d exp 4", pos_o); end
    step(1);
    n_cmp++; if (pos_o !== 4'd4) begin n_err++; $display("FAIL press_lat2 got %0d exp 4", pos_o); end
    step(1);
    n_cmp++; if (pos_o !== 4'd3) begin n_err++; $display("FAIL press_move got %0d exp 3", pos_o); end
    n_cmp++; if (paddle_o !== 16'h07F8) begin n_err++; $display("FAIL press_mask got %h exp 07f8", paddle_o); end
    step(2);
    n_cmp++; if (pos_o !== 4'd3) begin n_err++; $display("FAIL press_hold got %0d exp 3", pos_o); end
    up = 1'b0;
    step(3);
  endtask

  task automatic test_repeat();
    int chk_k [7] = '{11, 12, 14, 15, 18, 21, 30};
    int chk_p [7] = '{4, 5, 5, 6, 7, 8, 8};
    down = 1'b1;
    step(3);
    n_cmp++; if (pos_o !== 4'd4) begin n_err++; $display("FAIL repeat_press got %0d exp 4", pos_o); end
    for (int k = 1; k <= 30; k++) begin
      pulse_tick();
      for (int j = 0; j < 7; j++) begin
        if (k == chk_k[j]) begin
          n_cmp++;
          if (pos_o !== 4'(chk_p[j])) begin
            n_err++; $display("FAIL repeat_tick%0d got %0d exp %0d", k, pos_o, chk_p[j]);
          end
        end
      end
    end
    n_cmp++; if (paddle_o !== 16'hFF00) begin n_err++; $display("FAIL repeat_mask got %h exp ff00", paddle_o); end
    n_cmp++; if (at_bottom !== 1'b1) begin n_err++; $display("FAIL repeat_bottom got %b exp 1", at_bottom); end
    down = 1'b0;
    step(3);
  endtask

  task automatic test_width_clamp();
    width = 2'd3;
    #1;
    n_cmp++; if (paddle_o !== 16'h0300) begin n_err++; $display("FAIL w3_mask got %h exp 0300", paddle_o); end
    for (int n = 0; n < 4; n++) begin
      down = 1'b1; step(3);
      down = 1'b0; step(3);
    end
    n_cmp++; if (pos_o !== 4'd12) begin n_err++; $display("FAIL w3_pos got %0d exp 12", pos_o); end
    n_cmp++; if (paddle_o !== 16'h3000) begin n_err++; $display("FAIL w3_mask12 got %h exp 3000", paddle_o); end
    width = 2'd0;
    #1;
    n_cmp++; if (paddle_o !== 16'hF000) begin n_err++; $display("FAIL trunc_mask got %h exp f000", paddle_o); end
    n_cmp++; if (at_bottom !== 1'b0) begin n_err++; $display("FAIL trunc_bottom got %b exp 0", at_bottom); end
    step(1);
    n_cmp++; if (pos_o !== 4'd8) begin n_err++; $display("FAIL clamp_pos got %0d exp 8", pos_o); end
    n_cmp++; if (paddle_o !== 16'hFF00) begin n_err++; $display("FAIL clamp_mask got %h exp ff00", paddle_o); end
    n_cmp++; if (at_bottom !== 1'b1) begin n_err++; $display("FAIL clamp_bottom got %b exp 1", at_bottom); end
    up = 1'b1; down = 1'b1;
    step(6);
    n_cmp++; if (pos_o !== 4'd8) begin n_err++; $display("FAIL both_held got %0d exp 8", pos_o); end
    up = 1'b0; down = 1'b0;
    step(3);
  endtask

  task automatic test_auto();
    int exp_p;
    reset = 1'b1; width = 2'd0;
    step(1);
    reset = 1'b0; width = 2'd2;
    step(1);
    n_cmp++; if (paddle_o !== 16'h00F0) begin n_err++; $display("FAIL auto_start got %h exp 00f0", paddle_o); end
    auto_en = 1'b1; target = 4'd0;
    for (int k = 1; k <= 6; k++) begin
      pulse_tick();
      exp_p = (4 - k > 0) ? 4 - k : 0;
      n_cmp++; if (pos_o !== 4'(exp_p)) begin n_err++; $display("FAIL auto_up%0d got %0d exp %0d", k, pos_o, exp_p); end
    end
    n_cmp++; if (at_top !== 1'b1) begin n_err++; $display("FAIL auto_top got %b exp 1", at_top); end
    n_cmp++; if (paddle_o !== 16'h000F) begin n_err++; $display("FAIL auto_topmask got %h exp 000f", paddle_o); end
    target = 4'd15;
    for (int k = 1; k <= 14; k++) begin
      pulse_tick();
      exp_p = (k < 12) ? k : 12;
      n_cmp++; if (pos_o !== 4'(exp_p)) begin n_err++; $display("FAIL auto_dn%0d got %0d exp %0d", k, pos_o, exp_p); end
    end
    n_cmp++; if (paddle_o !== 16'hF000) begin n_err++; $display("FAIL auto_botmask got %h exp f000", paddle_o); end
    n_cmp++; if (at_bottom !== 1'b1) begin n_err++; $display("FAIL auto_bottom got %b exp 1", at_bottom); end
    target = 4'd7;
    for (int k = 1; k <= 10; k++) begin
      pulse_tick();
      exp_p = (12 - k > 5) ? 12 - k : 5;
      n_cmp++; if (pos_o !== 4'(exp_p)) begin n_err++; $display("FAIL auto_ctr%0d got %0d exp %0d", k, pos_o, exp_p); end
    end
    up = 1'b1;
    step(4);
    n_cmp++; if (pos_o !== 4'd5) begin n_err++; $display("FAIL auto_ignore got %0d exp 5", pos_o); end
    up = 1'b0;
    step(3);
    auto_en = 1'b0;
    step(1);
  endtask

  task automatic test_reset_mid_repeat();
    width = 2'd0;
    step(1);
    down = 1'b1;
    step(3);
    n_cmp++; if (pos_o !== 4'd6) begin n_err++; $display("FAIL mid_press got %0d exp 6", pos_o); end
    for (int k = 1; k <= 13; k++) pulse_tick();
    n_cmp++; if (pos_o !== 4'd7) begin n_err++; $display("FAIL mid_repeat got %0d exp 7", pos_o); end
    reset = 1'b1;
    step(1);
    n_cmp++; if (pos_o !== 4'd4) begin n_err++; $display("FAIL mid_reset got %0d exp 4", pos_o); end
    n_cmp++; if (paddle_o !== 16'h0FF0) begin n_err++; $display("FAIL mid_mask got %h exp 0ff0", paddle_o); end
    reset = 1'b0;
    step(1);
    n_cmp++; if (pos_o !== 4'd4) begin n_err++; $display("FAIL post_e1 got %0d exp 4", pos_o); end
    step(1);
    n_cmp++; if (pos_o !== 4'd4) begin n_err++; $display("FAIL post_e2 got %0d exp 4", pos_o); end
    step(1);
    n_cmp++; if (pos_o !== 4'd5) begin n_err++; $display("FAIL post_e3 got %0d exp 5", pos_o); end
    down = 1'b0;
    step(3);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_repeat();
    test_width_clamp();
    test_auto();
    test_reset_mid_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Parametrised, fully synchronous successor to the original paddle register.
- Holds one player's paddle as a position index plus a selectable width, and drives a ROWS-bit occupancy mask to the display/collision logic.
- Adds input synchronisation, press edge detection, hold-to-repeat timed by a frame tick, clamping on width change, and an auto (CPU-player) mode that tracks a target row.

Parameters:
- ROWS, 16, playfield height in rows; width of the mask output.
- W0, 8, paddle height for width=0.
- W1, 6, paddle height for width=1.
- W2, 4, paddle height for width=2.
- W3, 2, paddle height for width=3. All Wn are at least 1 and at most ROWS.
- REPEAT_DELAY, 12, ticks a button must be held before auto-repeat starts.
- REPEAT_RATE, 3, ticks between repeated moves once repeating.
- PW, $clog2(ROWS), position width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle frame strobe (e.g. vsync), timebase for repeat and auto mode.
- width  in  2  paddle size select (W0..W3).
- up  in  1  asynchronous button, active high; moves the paddle toward bit 0.
- down  in  1  asynchronous button, active high; moves the paddle toward bit ROWS-1.
- auto_en  in  1  1 = CPU control; buttons are ignored.
- target  in  PW  row the CPU tries to centre on; sampled on tick.
- paddle_o  out  ROWS  occupancy mask; bit i = 1 iff pos <= i < pos+W.
- pos_o  out  PW  current top (lowest) row index.
- at_top  out  1  pos == 0.
- at_bottom  out  1  pos + W == ROWS.

Behaviour:
- Clocking and reset
  - Single clock domain. Reset is synchronous and active-high: it is sampled on the clk rising edge and has priority over all other inputs.
  - Values after reset with width=0 and defaults: pos = (ROWS - W)/2 (floor), so pos=4 and paddle_o=16'h0FF0; at_top=0; at_bottom=0; sync flops=0; repeat state=IDLE; counters=0.
- Input path
  - up and down each pass through a 2-flop synchroniser, then a history flop.
  - press = sync & ~hist.
  - A press first sampled at edge N updates pos at edge N+2; the new value is visible on the outputs after that edge.
- Manual mode (auto_en=0)
  - Direction is up when only sync_up is set, down when only sync_down is set, none otherwise. Both held or neither held means no move and a return to IDLE.
  - Repeat FSM states: IDLE, DELAY, REPEAT.
  - IDLE: on press with a valid direction, move 1 row, cnt=0, go to DELAY.
  - DELAY: on tick, cnt++. When cnt reaches REPEAT_DELAY-1 on a tick: move 1, cnt=0, go to REPEAT.
  - REPEAT: on tick, cnt++. When cnt reaches REPEAT_RATE-1 on a tick: move 1, cnt=0.
  - Direction changing while held (e.g. up released and down pressed in the same cycle) counts as a new press: move once immediately and restart DELAY.
  - Release: go to IDLE in the same cycle; no move.
- Move rules
  - Up: pos-1, blocked when pos==0.
  - Down: pos+1, blocked when pos+W==ROWS.
  - A blocked move leaves pos unchanged, but the FSM still advances.
- Width change
  - W is combinational from width; paddle_o updates in the same cycle.
  - If pos+W > ROWS, pos is clamped to ROWS-W on the next edge. Until that edge the mask is truncated at ROWS-1; bits beyond ROWS-1 are never produced.
  - The clamp has priority over any move in the same cycle.
- Auto mode (auto_en=1)
  - Repeat FSM is forced to IDLE; up and down are ignored.
  - On each tick, centre c = pos + W/2 (floor). If target < c, move up; if target > c, move down; if equal, hold. Move rules still apply.
  - Toggling auto_en takes effect on the next edge; pos is retained.
- Arithmetic
  - pos+W is computed in PW+1 bits, with no wrap.
  - Mask is generated per bit with (i >= pos) && (i < pos+W).

Decomposition:
- Shared package pong_pkg: paddle width table function width_to_rows(width, W0..W3), repeat FSM state enum, and the ROWS default constant shared with the ball/collision blocks.
- One sub-module, btn_sync_edge: 2-flop synchroniser, history flop, and press/level outputs. It is instantiated twice, once for up and once for down.
- FSM, position datapath and mask generator stay in paddle_ctrl.

Test Plan (defaults):
- Reset with width=0 -> pos_o=4, paddle_o=16'h0FF0, at_top=0, at_bottom=0.
- From reset, single up pulse held 5 cycles with no tick -> pos_o=3 exactly 2 edges after first sample, paddle_o=16'h07F8, no further move.
- Hold down with tick every 4 clocks -> moves at press, at the 12th tick, then every 3rd tick. Stops at pos_o=8 with paddle_o=16'hFF00 and at_bottom=1; further ticks leave it unchanged.
- pos_o=12 with width=3 (W=2), then switch to width=0 -> paddle_o=16'hF000 for 1 cycle, then pos_o=8 and paddle_o=16'hFF00. Also hold both up and down -> no move.
- auto_en=1, width=2 (W=4), pos=4, target=0 -> one move up per tick until pos_o=0 (c=2 > 0, blocked at the top edge). Then target=15 -> moves down until pos_o=12 (c=14 < 15, blocked at the bottom edge).
- Assert reset mid-REPEAT while down is held -> next edge gives pos_o=4 and FSM IDLE. After reset deasserts with down still high, no move occurs until a fresh press edge (hist was cleared, so a press is detected 2 edges after release of reset).
